// File: rtl/rx_uart_cfg_pkg.sv
// rx_uart_cfg_pkg: shared types and baud table for the
// configurable UART receiver.
package rx_uart_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE3 = 2'd3
  } parity_e;

  localparam int FRAME_W = 10;

  function automatic int baud_rate(input logic [3:0] sel);
    int b;
    case (sel)
      4'd1:    b = 19200;
      4'd2:    b = 38400;
      4'd3:    b = 57600;
      4'd4:    b = 115200;
      default: b = 9600;
    endcase
    return b;
  endfunction

  function automatic int baud_div(
    input int         clk_hz,
    input int         os,
    input logic [3:0] sel
  );
    int d;
    d = clk_hz / (baud_rate(sel) * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/rx_uart_cfg_fifo.sv
// uart_rx_fifo: power-of-2 receive FIFO with separate
// occupancy count; head is read combinationally.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [CW-1:0]    cnt_q;
  logic             do_rd;
  logic             do_wr;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CW'(DEPTH));
  assign do_rd   = i_rd && !o_empty;
  // a pop in the same cycle frees the slot for a write on full
  assign do_wr   = i_wr && (!o_full || do_rd);
  assign o_rdata = o_empty ? '0 : mem[rp_q];

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wp_q] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      if (do_wr && !do_rd) cnt_q <= cnt_q + 1'b1;
      else if (!do_wr && do_rd) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/rx_uart_cfg.sv
// rx_uart_cfg: oversampling UART receiver with per-frame
// latched format, majority-vote bits and a receive FIFO.
module rx_uart_cfg
  import rx_uart_cfg_pkg::*;
#(
  parameter int CLK_HZ     = 1000000,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_sel_baud,
  input  logic [1:0] i_data_bits,
  input  logic [1:0] i_parity,
  input  logic       i_stop2,
  input  logic       i_Rx,
  output logic [7:0] o_Data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overrun,
  output logic       o_busy
);
  localparam int D0 = baud_div(CLK_HZ, OVERSAMPLE, 4'd0);
  localparam int D1 = baud_div(CLK_HZ, OVERSAMPLE, 4'd1);
  localparam int D2 = baud_div(CLK_HZ, OVERSAMPLE, 4'd2);
  localparam int D3 = baud_div(CLK_HZ, OVERSAMPLE, 4'd3);
  localparam int D4 = baud_div(CLK_HZ, OVERSAMPLE, 4'd4);
  localparam int DW = $clog2(D0 + 1);
  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] T_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] T_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] T_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] T_END = SW'(OVERSAMPLE - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s, rx_prev_q;
  logic          start_edge;
  logic [3:0]    sel_q;
  logic [1:0]    dbits_q;
  parity_e       par_q;
  logic          stop2_q;
  logic [DW-1:0] div_q, div_lim;
  logic [SW-1:0] s_q;
  logic          tick, chk, dec, armed_q;
  logic [1:0]    smp_q;
  logic          bit_v, last_bit, par_en, busy;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    data_q;
  logic          par_acc_q, perr_q, ferr_q;
  logic          wr_q, ovr_q, fifo_full, fifo_empty;

  assign rx_s       = sync_q[1];
  assign busy       = (state_q != S_IDLE);
  assign start_edge = !busy && rx_prev_q && !rx_s;
  assign tick       = busy && (div_q == div_lim);
  assign chk        = tick && (s_q == T_MID);
  assign dec        = tick && (s_q == T_HI) && armed_q;
  assign bit_v      = (smp_q[1] & smp_q[0]) |
                      (smp_q[1] & rx_s) |
                      (smp_q[0] & rx_s);
  assign last_bit   = (bit_cnt_q == 3'd4 + {1'b0, dbits_q});
  assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  always_comb begin
    div_lim = DW'(D0 - 1);
    case (sel_q)
      4'd1:    div_lim = DW'(D1 - 1);
      4'd2:    div_lim = DW'(D2 - 1);
      4'd3:    div_lim = DW'(D3 - 1);
      4'd4:    div_lim = DW'(D4 - 1);
      default: div_lim = DW'(D0 - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_edge) state_d = S_START;
      S_START:  if (chk) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (dec && last_bit)
                  state_d = par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (dec) state_d = S_STOP1;
      S_STOP1:  if (dec) state_d = stop2_q ? S_STOP2 : S_IDLE;
      S_STOP2:  if (dec) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      sel_q     <= '0;
      dbits_q   <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      div_q     <= '0;
      s_q       <= '0;
      smp_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_Rx};
      rx_prev_q <= rx_s;
      if (start_edge) begin
        sel_q   <= i_sel_baud;
        dbits_q <= i_data_bits;
        par_q   <= parity_e'(i_parity);
        stop2_q <= i_stop2;
      end
      if (!busy || tick) div_q <= '0;
      else               div_q <= div_q + 1'b1;
      if (!busy) s_q <= '0;
      else if (tick) s_q <= (s_q == T_END) ? '0 : s_q + 1'b1;
      if (tick && (s_q == T_LO || s_q == T_MID))
        smp_q <= {smp_q[0], rx_s};
      // START leaves before its own vote so bits decide on fresh samples
      if (start_edge || dec) armed_q <= 1'b0;
      else if (tick && s_q == T_LO && state_q != S_START)
        armed_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_acc_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wr_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (start_edge) begin
        bit_cnt_q <= '0;
        data_q    <= '0;
        par_acc_q <= 1'b0;
        perr_q    <= 1'b0;
        ferr_q    <= 1'b0;
      end else if (dec) begin
        if (state_q == S_DATA) begin
          data_q[bit_cnt_q] <= bit_v;
          bit_cnt_q         <= bit_cnt_q + 1'b1;
          par_acc_q         <= par_acc_q ^ bit_v;
        end
        if (state_q == S_PARITY)
          perr_q <= par_acc_q ^ bit_v ^ (par_q == PAR_ODD);
        if ((state_q == S_STOP1 || state_q == S_STOP2) && !bit_v)
          ferr_q <= 1'b1;
      end
      wr_q  <= dec && ((state_q == S_STOP1 && !stop2_q) ||
                       state_q == S_STOP2);
      ovr_q <= wr_q && fifo_full && !i_ready;
    end
  end

  uart_rx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (wr_q),
    .i_wdata ({ferr_q, perr_q, data_q}),
    .i_rd    (i_ready),
    .o_rdata ({o_frame_err, o_parity_err, o_Data}),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_valid   = !fifo_empty;
  assign o_overrun = ovr_q;
  assign o_busy    = busy;

endmodule

// File: doc/rx_uart_cfg.md
RX_UART_CFG -- requirements
Module: rx_uart_cfg

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning samples per bit (even, 8..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of 2, >=2).
REQ-004 SHALL have port i_clk, input, 1, meaning the single system clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port i_sel_baud, input, 4, meaning baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, others=9600.
REQ-007 SHALL have port i_data_bits, input, 2, meaning data length 5+value (5..8).
REQ-008 SHALL have port i_parity, input, 2, meaning 0=none, 1=even, 2=odd, 3=none.
REQ-009 SHALL have port i_stop2, input, 1, meaning 1 = two stop bits checked.
REQ-010 SHALL have port i_Rx, input, 1, meaning asynchronous serial line, idle high.
REQ-011 SHALL have port o_Data, output, 8, meaning FIFO head byte, LSB-first assembled, unused MSBs zero.
REQ-012 SHALL have port o_valid, output, 1, meaning FIFO non-empty.
REQ-013 SHALL have port i_ready, input, 1, meaning consumer pop; pop occurs when o_valid&&i_ready.
REQ-014 SHALL have port o_frame_err, output, 1, meaning head entry had a low stop bit.
REQ-015 SHALL have port o_parity_err, output, 1, meaning head entry failed parity.
REQ-016 SHALL have port o_overrun, output, 1, meaning one-cycle pulse when a completed frame is dropped because the FIFO is full.
REQ-017 SHALL have port o_busy, output, 1, meaning receiver not in IDLE.

Function
REQ-018 SHALL pass i_Rx through a 2-flop synchroniser before any use.
REQ-019 SHALL generate a sample tick every DIV = CLK_HZ/(baud*OVERSAMPLE) clocks (integer truncation, minimum 1); divider restarts on start-edge detection.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-021 IDLE->START on a synchronised high-to-low transition; config inputs latched at this transition, mid-frame changes ignored.
REQ-022 START: at tick OVERSAMPLE/2 line still low -> DATA, else false start -> IDLE with nothing written.
REQ-023 Each bit SHALL be decided by majority of samples at ticks OVERSAMPLE/2-1, /2, /2+1 of that bit.
REQ-024 DATA SHALL collect latched-length bits LSB first, then go to PARITY if parity enabled, else STOP1.
REQ-025 PARITY error SHALL be set when XOR of data bits plus parity bit is 1 (even) or 0 (odd).
REQ-026 STOP1 sampled low SHALL set frame error; STOP1->STOP2 if i_stop2 latched, else complete; STOP2 low also sets frame error.
REQ-027 On completion, {frame_err, parity_err, data} SHALL be written to FIFO the cycle after the final stop-bit decision and state returns to IDLE the same cycle.
REQ-028 A break (all data zero, frame error) SHALL be stored as a normal entry; return to IDLE waits until line is high before a new start is accepted.
REQ-029 Write to full FIFO SHALL drop the frame and pulse o_overrun; simultaneous pop and write on full SHALL succeed with no overrun.
REQ-030 o_Data, o_frame_err, o_parity_err SHALL reflect the FIFO head combinationally from registered storage; zero when empty.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH with a separate count for full/empty.

Reset
REQ-032 While i_rst=0 SHALL hold IDLE, FIFO empty, divider cleared, synchroniser set to 1, all outputs 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; first start edge after release SHALL be received normally.

Structure
REQ-034 A shared package SHALL hold the state enumeration, parity encodings, and the baud-rate table.
REQ-035 The receive FIFO SHALL be a sub-module named uart_rx_fifo (parameters WIDTH, DEPTH).

Verification
REQ-036 Defaults, sel 0 (DIV=6, 96 clocks/bit), 8N1: send 0x41,0x42,0x43,0x44 with i_ready=1 -> four pops of 0x41..0x44, no errors.
REQ-037 7E2, send 0x35 with correct parity -> o_Data=0x35, o_parity_err=0; flip parity bit -> o_parity_err=1.
REQ-038 8N1, send 0x55 with stop bit driven low -> entry 0x55 with o_frame_err=1; next byte 0xA5 correct.
REQ-039 i_ready=0, send 5 bytes 0x01..0x05 -> o_overrun pulses once; pops return 0x01..0x04.
REQ-040 Low glitch of 30 clocks on idle line -> no entry, o_busy returns 0; assert reset mid-byte then send 0x7E -> single entry 0x7E.
